// File: rtl/proc_core.sv
// Multi-cycle ECE350-ISA core: FETCH/DECODE/EXEC(/MEM) sequencing over an
// external synchronous ROM, synchronous RAM and combinational-read regfile.
module proc_core (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] FN_ADD = 5'b00000;
  localparam logic [4:0] FN_SUB = 5'b00001;
  localparam logic [4:0] FN_AND = 5'b00010;
  localparam logic [4:0] FN_OR  = 5'b00011;
  localparam logic [4:0] FN_SLL = 5'b00100;
  localparam logic [4:0] FN_SRA = 5'b00101;

  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] pc_next_q;
  logic        we_q;
  logic [4:0]  wr_reg_q;
  logic [31:0] wr_data_q;
  logic        wren_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_data_q;

  // The instruction word comes straight from the ROM while decoding, from IR otherwise.
  logic [31:0] instr;
  logic [4:0]  op, rd, rs, rt, shamt, aluop;
  logic [31:0] imm_sx, tgt;

  assign instr  = (state == S_DECODE) ? q_imem : ir;
  assign op     = instr[31:27];
  assign rd     = instr[26:22];
  assign rs     = instr[21:17];
  assign rt     = instr[16:12];
  assign shamt  = instr[11:7];
  assign aluop  = instr[6:2];
  assign imm_sx = {{15{instr[16]}}, instr[16:0]};
  assign tgt    = {5'd0, instr[26:0]};

  always_comb begin
    ctrl_readRegA = (op == OP_JR) ? rd : rs;
    if (op == OP_R)
      ctrl_readRegB = rt;
    else if (op == OP_BEX)
      ctrl_readRegB = REG_STATUS;
    else
      ctrl_readRegB = rd;
  end

  logic [31:0] a, b;
  logic [31:0] sum_ab, dif_ab, sum_ai, pc_inc, pc_br;
  logic        ovf_add, ovf_sub, ovf_addi;

  assign a        = data_readRegA;
  assign b        = data_readRegB;
  assign sum_ab   = a + b;
  assign dif_ab   = a - b;
  assign sum_ai   = a + imm_sx;
  assign pc_inc   = pc + 32'd1;
  assign pc_br    = pc_inc + imm_sx;
  assign ovf_add  = (a[31] == b[31])      && (sum_ab[31] != a[31]);
  assign ovf_sub  = (a[31] != b[31])      && (dif_ab[31] != a[31]);
  assign ovf_addi = (a[31] == imm_sx[31]) && (sum_ai[31] != a[31]);

  // Every EXEC-cycle effect is resolved during DECODE, while the regfile
  // operands are valid, and registered so EXEC outputs come from flops.
  logic        dec_we;
  logic [4:0]  dec_reg;
  logic [31:0] dec_val;
  logic        dec_sw;
  logic [31:0] dec_addr;
  logic [31:0] dec_next;

  always_comb begin
    dec_we   = 1'b0;
    dec_reg  = rd;
    dec_val  = '0;
    dec_sw   = 1'b0;
    dec_addr = '0;
    dec_next = pc_inc;
    case (op)
      OP_R: begin
        case (aluop)
          FN_ADD: begin
            dec_we = 1'b1;
            if (ovf_add) begin
              dec_reg = REG_STATUS;
              dec_val = 32'd1;
            end else begin
              dec_val = sum_ab;
            end
          end
          FN_SUB: begin
            dec_we = 1'b1;
            if (ovf_sub) begin
              dec_reg = REG_STATUS;
              dec_val = 32'd3;
            end else begin
              dec_val = dif_ab;
            end
          end
          FN_AND: begin
            dec_we  = 1'b1;
            dec_val = a & b;
          end
          FN_OR: begin
            dec_we  = 1'b1;
            dec_val = a | b;
          end
          FN_SLL: begin
            dec_we  = 1'b1;
            dec_val = a << shamt;
          end
          FN_SRA: begin
            dec_we  = 1'b1;
            dec_val = $signed(a) >>> shamt;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        dec_we = 1'b1;
        if (ovf_addi) begin
          dec_reg = REG_STATUS;
          dec_val = 32'd2;
        end else begin
          dec_val = sum_ai;
        end
      end
      OP_LW: dec_addr = sum_ai;
      OP_SW: begin
        dec_addr = sum_ai;
        dec_sw   = 1'b1;
      end
      OP_J: dec_next = tgt;
      OP_JAL: begin
        dec_we   = 1'b1;
        dec_reg  = REG_LINK;
        dec_val  = pc_inc;
        dec_next = tgt;
      end
      OP_JR: dec_next = a;
      OP_BNE: if (b != a) dec_next = pc_br;
      OP_BLT: if ($signed(b) < $signed(a)) dec_next = pc_br;
      OP_BEX: if (b != '0) dec_next = tgt;
      OP_SETX: begin
        dec_we  = 1'b1;
        dec_reg = REG_STATUS;
        dec_val = tgt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      pc          <= '0;
      ir          <= '0;
      pc_next_q   <= '0;
      we_q        <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      wren_q      <= 1'b0;
      dmem_addr_q <= '0;
      dmem_data_q <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          we_q   <= 1'b0;
          wren_q <= 1'b0;
          state  <= S_DECODE;
        end
        S_DECODE: begin
          ir          <= q_imem;
          we_q        <= dec_we && (dec_reg != '0);
          wr_reg_q    <= dec_reg;
          wr_data_q   <= dec_val;
          wren_q      <= dec_sw;
          dmem_addr_q <= dec_addr;
          dmem_data_q <= dec_sw ? b : '0;
          pc_next_q   <= dec_next;
          state       <= S_EXEC;
        end
        S_EXEC: begin
          pc     <= pc_next_q;
          wren_q <= 1'b0;
          if (ir[31:27] == OP_LW) begin
            we_q     <= (ir[26:22] != '0);
            wr_reg_q <= ir[26:22];
            state    <= S_MEM;
          end else begin
            we_q  <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          we_q  <= 1'b0;
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign address_imem     = pc;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wr_reg_q;
  assign data_writeReg    = (state == S_MEM) ? q_dmem : wr_data_q;
  assign wren             = wren_q;
  assign address_dmem     = dmem_addr_q;
  assign data             = dmem_data_q;

endmodule

// File: tb/tb_proc_core.sv
// Bench for proc_core: models ROM/RAM/regfile around the core and compares
// against an instruction-level reference of the ISA.
module tb_proc_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_imem, q_imem, data_writeReg, data_readRegA, data_readRegB;
  logic [31:0] address_dmem, data, q_dmem;
  logic        ctrl_writeEnable, wren;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;

  proc_core dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  logic [31:0] rom [4096];
  logic [31:0] ram [4096];
  logic [31:0] rf  [32];
  logic [31:0] ld_ram [4096];
  logic [31:0] ld_rf  [32];
  logic        load_now = 1'b0;
  int          wren_cycles = 0;
  int          r0_writes = 0;
  logic [31:0] last_st_addr = '0;

  logic [31:0] m_ram [4096];
  logic [31:0] m_rf  [32];
  logic [31:0] m_pc;
  int          m_sw;

  int n_cmp = 0;
  int n_bad = 0;

  // Memories and regfile seen by the core; preload only while the core is in reset.
  always @(posedge clock) begin
    q_imem <= rom[address_imem[11:0]];
    q_dmem <= ram[address_dmem[11:0]];
    if (load_now) begin
      for (int i = 0; i < 4096; i++) ram[i] = ld_ram[i];
      for (int i = 0; i < 32; i++) rf[i] = ld_rf[i];
    end else begin
      if (wren) begin
        ram[address_dmem[11:0]] = data;
        wren_cycles++;
        last_st_addr = address_dmem;
      end
      if (ctrl_writeEnable) begin
        if (ctrl_writeReg == 5'd0) r0_writes++;
        else rf[ctrl_writeReg] = data_writeReg;
      end
    end
  end

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? '0 : rf[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? '0 : rf[ctrl_readRegB];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] sh);
    return {5'd0, rd, rs, rt, sh, fn, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_t(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  // ---------------- instruction-level reference ----------------
  function automatic logic [31:0] rv(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : m_rf[i];
  endfunction

  function automatic void wr(input logic [4:0] i, input logic [31:0] v);
    if (i != 5'd0) m_rf[i] = v;
  endfunction

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic bit fits(input longint s);
    return (s >= -64'sd2147483648) && (s <= 64'sd2147483647);
  endfunction

  task automatic model_step(output int cyc);
    logic [31:0] ins, imm, t, x, y, nxt, ea;
    logic [4:0]  op, rd, rs, rt, sh, fn;
    longint      s;
    ins = rom[m_pc[11:0]];
    op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
    sh = ins[11:7];  fn = ins[6:2];
    imm = {{15{ins[16]}}, ins[16:0]};
    t   = {5'd0, ins[26:0]};
    nxt = m_pc + 32'd1;
    ea  = rv(rs) + imm;
    cyc = 3;
    case (op)
      5'd0: begin
        x = rv(rs); y = rv(rt);
        case (fn)
          5'd0: begin s = sx(x) + sx(y); if (fits(s)) wr(rd, s[31:0]); else wr(5'd30, 32'd1); end
          5'd1: begin s = sx(x) - sx(y); if (fits(s)) wr(rd, s[31:0]); else wr(5'd30, 32'd3); end
          5'd2: wr(rd, x & y);
          5'd3: wr(rd, x | y);
          5'd4: wr(rd, x << sh);
          5'd5: wr(rd, 32'($signed(x) >>> sh));
          default: ;
        endcase
      end
      5'd5: begin s = sx(rv(rs)) + sx(imm); if (fits(s)) wr(rd, s[31:0]); else wr(5'd30, 32'd2); end
      5'd8: begin cyc = 4; wr(rd, m_ram[ea[11:0]]); end
      5'd7: begin m_ram[ea[11:0]] = rv(rd); m_sw++; end
      5'd1: nxt = t;
      5'd3: begin wr(5'd31, m_pc + 32'd1); nxt = t; end
      5'd4: nxt = rv(rd);
      5'd2: if (rv(rd) != rv(rs)) nxt = m_pc + 32'd1 + imm;
      5'd6: if ($signed(rv(rd)) < $signed(rv(rs))) nxt = m_pc + 32'd1 + imm;
      5'd22: if (rv(5'd30) != 32'd0) nxt = t;
      5'd21: wr(5'd30, t);
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // Steps model and DUT together; entry point is a FETCH-state negedge.
  task automatic run_lockstep(input int n, input string tag);
    int c;
    for (int i = 0; i < n; i++) begin
      check({tag, "_pc"}, address_imem, m_pc);
      model_step(c);
      repeat (c) @(negedge clock);
    end
  endtask

  task automatic do_load();
    load_now = 1'b1;
    @(posedge clock);
    #1 load_now = 1'b0;
    for (int i = 0; i < 4096; i++) m_ram[i] = ld_ram[i];
    for (int i = 0; i < 32; i++) m_rf[i] = ld_rf[i];
    m_pc = '0;
    m_sw = 0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 15))
      0, 1, 2, 3: begin w[31:27] = 5'd0; w[6:2] = 5'($urandom_range(0, 7)); end
      4, 14:      w[31:27] = 5'd5;
      5:          w[31:27] = 5'd8;
      6:          w[31:27] = 5'd7;
      7:          w[31:27] = 5'd1;
      8:          w[31:27] = 5'd3;
      9:          w[31:27] = 5'd4;
      10:         w[31:27] = 5'd2;
      11:         w[31:27] = 5'd6;
      12:         w[31:27] = 5'd22;
      13:         w[31:27] = 5'd21;
      default:    w[31:27] = 5'b11111;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'h7FFF_FFFF - 32'($urandom_range(0, 15));
      2:       return 32'h8000_0000 + 32'($urandom_range(0, 15));
      default: return 32'($urandom_range(0, 20));
    endcase
  endfunction

  initial begin
    int          c, diffs, w0, r00;
    logic [8:0]  we_vec;

    // ---------------- directed program ----------------
    for (int i = 0; i < 4096; i++) begin rom[i] = '0; ld_ram[i] = '0; end
    for (int i = 0; i < 32; i++) ld_rf[i] = '0;
    rom[0]  = enc_i(5'd5, 5'd1, 5'd0, 17'd5);
    rom[1]  = enc_i(5'd5, 5'd2, 5'd0, 17'd7);
    rom[2]  = enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd0);
    rom[3]  = enc_i(5'd7, 5'd2, 5'd0, 17'd3);
    rom[4]  = enc_i(5'd8, 5'd4, 5'd0, 17'd3);
    rom[5]  = enc_i(5'd2, 5'd1, 5'd2, 17'd2);
    rom[6]  = enc_i(5'd5, 5'd5, 5'd0, 17'd1);
    rom[7]  = enc_i(5'd5, 5'd5, 5'd0, 17'd2);
    rom[8]  = enc_i(5'd6, 5'd2, 5'd1, 17'd2);
    rom[9]  = enc_t(5'd3, 27'd20);
    rom[10] = enc_t(5'd21, 27'd9);
    rom[11] = enc_t(5'd22, 27'd30);
    rom[20] = enc_i(5'd5, 5'd6, 5'd0, 17'd1);
    rom[21] = enc_t(5'd4, {5'd31, 22'd0});
    rom[30] = enc_i(5'd5, 5'd8, 5'd0, 17'h07FFF);
    rom[31] = enc_r(5'd4, 5'd8, 5'd8, 5'd0, 5'd16);
    rom[32] = enc_r(5'd0, 5'd9, 5'd8, 5'd8, 5'd0);
    rom[33] = enc_i(5'd5, 5'd12, 5'd30, 17'd0);
    rom[34] = enc_i(5'd5, 5'd10, 5'd0, 17'h1FFFF);
    rom[35] = enc_r(5'd4, 5'd10, 5'd10, 5'd0, 5'd31);
    rom[36] = enc_r(5'd1, 5'd11, 5'd8, 5'd10, 5'd0);
    rom[37] = enc_t(5'd1, 27'd37);
    do_load();
    #1;
    check("rst_pc",    address_imem, 64'd0);
    check("rst_ctrl",  {ctrl_writeEnable, wren, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB}, 64'd0);
    check("rst_wdata", data_writeReg, 64'd0);
    check("rst_dmem",  {address_dmem, data}, 64'd0);

    @(negedge clock) reset = 1'b1;
    we_vec = '0;
    for (int i = 0; i < 3; i++) begin
      check("dir_pc", address_imem, m_pc);
      model_step(c);
      for (int j = 0; j < c; j++) begin
        we_vec[i*3+j] = ctrl_writeEnable;
        @(negedge clock);
      end
    end
    check("we_timing", we_vec, 64'b100_100_100);
    run_lockstep(19, "dir");
    check("r3_add",      rf[3], 64'd12);
    check("r4_lw",       rf[4], 64'd7);
    check("r5_skipped",  rf[5], 64'd0);
    check("r6_jal_body", rf[6], 64'd1);
    check("r31_link",    rf[31], 64'd10);
    check("r8_shift",    rf[8], 64'h7FFF_0000);
    check("r9_add_ovf",  rf[9], 64'd0);
    check("r12_st_add",  rf[12], 64'd1);
    check("r11_sub_ovf", rf[11], 64'd0);
    check("r30_sub_ovf", rf[30], 64'd3);
    check("ram3",        ram[3], 64'd7);
    check("sw_cycles",   wren_cycles, 64'd1);
    check("sw_addr",     last_st_addr, 64'd3);

    // ---------------- reset during EXEC of sw ----------------
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) begin rom[i] = '0; ld_ram[i] = '0; end
    for (int i = 0; i < 32; i++) ld_rf[i] = '0;
    ld_rf[2]  = 32'h55;
    ld_ram[5] = 32'hDEAD;
    rom[0] = enc_i(5'd5, 5'd1, 5'd0, 17'd1);
    rom[1] = enc_i(5'd7, 5'd2, 5'd0, 17'd5);
    do_load();
    w0 = wren_cycles;
    @(negedge clock) reset = 1'b1;
    repeat (5) @(negedge clock);
    check("sw_exec_wren", wren, 64'd1);
    check("sw_exec_pc",   address_imem, 64'd1);
    reset = 1'b0;
    #1;
    check("abort_wren", {wren, ctrl_writeEnable}, 64'd0);
    check("abort_pc",   address_imem, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("abort_ram5",   ram[5], 64'hDEAD);
    check("abort_cycles", wren_cycles - w0, 64'd0);
    check("restart_pc0",  address_imem, 64'd0);
    repeat (3) @(negedge clock);
    check("restart_pc1",  address_imem, 64'd1);

    // ---------------- randomized programs vs reference ----------------
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) begin rom[i] = rnd_instr(); ld_ram[i] = $urandom; end
    ld_rf[0] = '0;
    for (int i = 1; i < 32; i++) ld_rf[i] = rnd_val();
    do_load();
    w0  = wren_cycles;
    r00 = r0_writes;
    @(negedge clock) reset = 1'b1;
    run_lockstep(400, "rnd");
    for (int i = 1; i < 32; i++) check($sformatf("rnd_r%0d", i), rf[i], m_rf[i]);
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== m_ram[i]) diffs++;
    check("rnd_ram_diffs", diffs, 64'd0);
    check("rnd_sw_cycles", wren_cycles - w0, m_sw);
    check("rnd_r0_writes", r0_writes - r00, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
